pixel_cmd_parser: RTL and testbench

PIXEL_CMD_PARSER -- requirements
Module: pixel_cmd_parser

---
 rtl/pixel_cmd_parser_pkg.sv | 12 +
 rtl/pixel_cmd_parser.sv | 88 ++++++++
 tb/tb_pixel_cmd_parser.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_cmd_parser_pkg.sv
// pixel_cmd_parser_pkg: command codes and parser states shared with the host-side encoder
package pixel_cmd_parser_pkg;

    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_FILL  = 8'h02;

    typedef enum logic [3:0] {
        IDLE, A2, A1, A0, N1, N0, C1, C0, PH, PL, PWR, FWR
    } state_t;

endpackage

// File: rtl/pixel_cmd_parser.sv
// pixel_cmd_parser: turns decoded COBS bytes into WRITE/FILL frame-buffer pixel writes
module pixel_cmd_parser
    import pixel_cmd_parser_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 742_000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_FLAG,
    input  logic [7:0]        IN_DATA,
    output logic              BUSY,
    output logic              WR_VALID,
    input  logic              WR_READY,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [15:0]       WR_DATA,
    output logic              ERR
);

    state_t      state;
    logic        fill;
    logic [16:0] cnt;
    logic [19:0] tmo;
    logic        take, xfer, timed, tmo_hit;

    assign BUSY     = state == PWR || state == FWR;
    assign WR_VALID = BUSY;
    assign take     = IN_FLAG && !BUSY;
    assign xfer     = BUSY && WR_READY;
    assign timed    = !(state inside {IDLE, PWR, FWR});
    assign tmo_hit  = timed && !take && (32'(tmo) + 1 >= TIMEOUT);

    // command sequencing, byte capture, write handshake, timeout and error pulse
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            fill    <= 1'b0;
            cnt     <= '0;
            tmo     <= '0;
            WR_ADDR <= '0;
            WR_DATA <= '0;
            ERR     <= 1'b0;
        end else begin
            ERR <= (IN_FLAG && BUSY) || (take && state == IDLE && IN_DATA > CMD_FILL) || tmo_hit;
            tmo <= (!timed || take) ? '0 : tmo + 20'd1;
            if (tmo_hit) begin
                state <= IDLE;
            end else if (take) begin
                case (state)
                    IDLE: begin
                        fill  <= IN_DATA == CMD_FILL;
                        state <= (IN_DATA == CMD_WRITE || IN_DATA == CMD_FILL) ? A2 : IDLE;
                    end
                    A2, A1, A0: begin
                        WR_ADDR <= ADDR_W'({WR_ADDR, IN_DATA});
                        state   <= state == A2 ? A1 : state == A1 ? A0 : fill ? N1 : N0;
                    end
                    N1: begin
                        cnt   <= {1'b0, IN_DATA, 8'h00};
                        state <= N0;
                    end
                    N0: begin
                        cnt   <= fill ? {cnt[16:8], IN_DATA} : IN_DATA == 8'h00 ? 17'd256 : {9'd0, IN_DATA};
                        state <= fill ? C1 : PH;
                    end
                    C1, PH: begin
                        WR_DATA[15:8] <= IN_DATA;
                        state         <= state == C1 ? C0 : PL;
                    end
                    C0: begin
                        WR_DATA[7:0] <= IN_DATA;
                        state        <= cnt == 17'd0 ? IDLE : FWR;
                    end
                    PL: begin
                        WR_DATA[7:0] <= IN_DATA;
                        state        <= PWR;
                    end
                    default: ;
                endcase
            end else if (xfer) begin
                WR_ADDR <= WR_ADDR + 1'b1;
                cnt     <= cnt - 17'd1;
                state   <= cnt == 17'd1 ? IDLE : state == PWR ? PH : FWR;
            end
        end
    end

endmodule

// File: tb/tb_pixel_cmd_parser.sv
// tb_pixel_cmd_parser: directed and randomized checks against a queue-based write model
module tb_pixel_cmd_parser;
    import pixel_cmd_parser_pkg::*;

    localparam int TMO = 64;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        IN_FLAG = 1'b0;
    logic [7:0]  IN_DATA = 8'h00;
    logic        WR_READY = 1'b1;
    logic        BUSY, WR_VALID, ERR;
    logic [19:0] WR_ADDR;
    logic [15:0] WR_DATA;

    pixel_cmd_parser #(.ADDR_W(20), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .IN_FLAG(IN_FLAG), .IN_DATA(IN_DATA), .BUSY(BUSY),
        .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [19:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e_m;
    int          checks = 0;
    int          failures = 0;
    int          xfers = 0;
    int          x0;
    int          rdy_mode = 0;
    logic [15:0] pix [0:1];
    logic        stall = 1'b0;
    logic [19:0] sa;
    logic [15:0] sd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ready pattern: 0 always high, 1 toggling, 2 random, 3 held low
    always @(posedge CLK) begin
        #2;
        case (rdy_mode)
            0: WR_READY = 1'b1;
            1: WR_READY = ~WR_READY;
            2: WR_READY = 1'($urandom_range(0, 1));
            default: WR_READY = 1'b0;
        endcase
    end

    // write monitor: every transfer must match the model, stalled requests must hold
    always @(negedge CLK) begin
        if (RST) begin
            if (stall) begin
                chk("hold_valid", 32'(WR_VALID), 1);
                chk("hold_addr", 32'(WR_ADDR), 32'(sa));
                chk("hold_data", 32'(WR_DATA), 32'(sd));
            end
            stall = WR_VALID && !WR_READY;
            sa = WR_ADDR;
            sd = WR_DATA;
            if (WR_VALID && WR_READY) begin
                xfers++;
                if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    e_m = exp_q.pop_front();
                    chk("wr_addr", 32'(WR_ADDR), 32'(e_m.a));
                    chk("wr_data", 32'(WR_DATA), 32'(e_m.d));
                end
            end
        end else stall = 1'b0;
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge CLK);
        while (BUSY && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 5000) begin
            chk("busy_stuck", 32'(BUSY), 0);
            return;
        end
        IN_FLAG = 1'b1;
        IN_DATA = b;
        @(posedge CLK);
        #1 IN_FLAG = 1'b0;
    endtask

    task automatic cmd_write(input logic [23:0] a24, input int n, input bit fixed);
        logic [15:0] p;
        send(CMD_WRITE);
        send(a24[23:16]);
        send(a24[15:8]);
        send(a24[7:0]);
        send(8'(n));
        for (int i = 0; i < n; i++) begin
            p = (fixed && i < 2) ? pix[i] : 16'($urandom);
            exp_q.push_back('{a24[19:0] + 20'(i), p});
            send(p[15:8]);
            send(p[7:0]);
        end
    endtask

    task automatic cmd_fill(input logic [23:0] a24, input logic [15:0] n, input logic [15:0] c);
        for (int i = 0; i < int'(n); i++) exp_q.push_back('{a24[19:0] + 20'(i), c});
        send(CMD_FILL);
        send(a24[23:16]);
        send(a24[15:8]);
        send(a24[7:0]);
        send(n[15:8]);
        send(n[7:0]);
        send(c[15:8]);
        send(c[7:0]);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || BUSY) && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        chk("drain", 32'(exp_q.size()), 0);
        chk("idle_busy", 32'(BUSY), 0);
        chk("idle_valid", 32'(WR_VALID), 0);
    endtask

    initial begin
        int j;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_valid", 32'(WR_VALID), 0);
        chk("rst_err", 32'(ERR), 0);
        chk("rst_addr", 32'(WR_ADDR), 0);
        chk("rst_data", 32'(WR_DATA), 0);
        RST = 1'b1;

        pix[0] = 16'hF800;
        pix[1] = 16'h07E0;
        x0 = xfers;
        cmd_write(24'h000100, 2, 1'b1);
        wait_done();
        chk("write2_count", 32'(xfers - x0), 2);

        x0 = xfers;
        cmd_fill(24'h000010, 16'd5, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("fill_back2back", 32'(WR_VALID), 1);
        end
        @(negedge CLK);
        chk("fill_end_valid", 32'(WR_VALID), 0);
        wait_done();
        chk("fill5_count", 32'(xfers - x0), 5);

        rdy_mode = 1;
        x0 = xfers;
        cmd_fill(24'h000010, 16'd5, 16'hFFFF);
        wait_done();
        chk("fill5_toggle_count", 32'(xfers - x0), 5);
        rdy_mode = 0;

        x0 = xfers;
        send(8'h7F);
        chk("bad_cmd_err", 32'(ERR), 1);
        @(posedge CLK);
        #1 chk("bad_cmd_err_single", 32'(ERR), 0);
        cmd_write(24'h0ABCDE, 3, 1'b0);
        wait_done();
        chk("after_err_count", 32'(xfers - x0), 3);

        rdy_mode = 3;
        x0 = xfers;
        cmd_fill(24'h000200, 16'd3, 16'h1234);
        @(negedge CLK);
        chk("busy_hold", 32'(BUSY), 1);
        IN_FLAG = 1'b1;
        IN_DATA = 8'hAA;
        @(posedge CLK);
        #1 IN_FLAG = 1'b0;
        chk("busy_drop_err", 32'(ERR), 1);
        chk("busy_still", 32'(BUSY), 1);
        rdy_mode = 0;
        wait_done();
        chk("busy_drop_count", 32'(xfers - x0), 3);

        rdy_mode = 2;
        x0 = xfers;
        cmd_write(24'hFFFFFF, 256, 1'b0);
        wait_done();
        chk("wrap256_count", 32'(xfers - x0), 256);

        rdy_mode = 0;
        send(CMD_WRITE);
        send(8'h00);
        send(8'h00);
        j = 0;
        for (int i = 1; i <= TMO + 5; i++) begin
            @(posedge CLK);
            #1;
            if (ERR) begin
                j = i;
                break;
            end
        end
        chk("timeout_cycles", 32'(j), TMO);
        x0 = xfers;
        cmd_fill(24'h000500, 16'd4, 16'hBEEF);
        wait_done();
        chk("after_timeout_count", 32'(xfers - x0), 4);

        x0 = xfers;
        cmd_fill(24'h000300, 16'd0, 16'h5555);
        wait_done();
        chk("fill0_count", 32'(xfers - x0), 0);

        rdy_mode = 2;
        repeat (15) begin
            x0 = exp_q.size();
            if ($urandom_range(0, 3) == 0) send(CMD_NOP);
            if ($urandom_range(0, 1) == 0) cmd_write(24'($urandom), $urandom_range(1, 6), 1'b0);
            else cmd_fill(24'($urandom), 16'($urandom_range(0, 10)), 16'($urandom));
            wait_done();
        end

        cmd_fill(24'h000400, 16'd300, 16'hA5A5);
        repeat (10) @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_fwr_valid", 32'(WR_VALID), 0);
        chk("rst_fwr_busy", 32'(BUSY), 0);
        chk("rst_fwr_addr", 32'(WR_ADDR), 0);
        chk("rst_fwr_data", 32'(WR_DATA), 0);
        exp_q.delete();
        RST = 1'b1;
        x0 = xfers;
        repeat (20) @(posedge CLK);
        #1 chk("rst_fwr_no_writes", 32'(xfers - x0), 0);
        cmd_write(24'h001000, 2, 1'b0);
        wait_done();
        chk("rst_recover_count", 32'(xfers - x0), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
